// File: rtl/lcd_init_sequencer_if.sv
// ----------------------------------------------------------------------------
// lcd_init_sequencer_if
//   Host request handshake for the LCD init sequencer.
//   iReq_Valid  host request present
//   iReq_RS     0 = command, 1 = DDRAM data
//   iReq_Data   byte to write
//   oReq_Ready  sequencer accepts a request this cycle
//   Modports: master = requester (application logic), slave = sequencer.
// ----------------------------------------------------------------------------
interface lcd_init_sequencer_if;
    logic       iReq_Valid;
    logic       iReq_RS;
    logic [7:0] iReq_Data;
    logic       oReq_Ready;

    modport master (output iReq_Valid, output iReq_RS, output iReq_Data, input  oReq_Ready);
    modport slave  (input  iReq_Valid, input  iReq_RS, input  iReq_Data, output oReq_Ready);
endinterface

// File: rtl/lcd_init_sequencer.sv
// ----------------------------------------------------------------------------
// lcd_init_sequencer
//   Sequences the 4-bit LCD writer for the Spartan-3E character LCD: power-on
//   wait, the 3,3,3,2 init nibbles, the configuration bytes 0x28,0x06,0x0C,0x01,
//   then one host command/data byte at a time. Also drives LCD RS/RW.
// Ports
//   Clock       system clock
//   Reset       synchronous, active-low
//   req         host handshake (lcd_init_sequencer_if.slave)
//   oInit_Done  init/config complete, sticky until reset
//   oLCD_RS     LCD register select (changes only while oWr_Go=0)
//   oLCD_RW     LCD read/write, tied 0
//   oWr_Go      writer active-low reset; 1 = writer runs
//   oWr_Mode    0 = single nibble, 1 = byte
//   oWr_Nibble  nibble for mode 0
//   oWr_Byte    byte for mode 1, nibble-swapped {data[3:0],data[7:4]}
//   iWr_Done    writer done pulse
// Build option
//   LCD_LINE_WRAP_EN  when defined, a column counter inserts 0xC0 after the
//                     16th data byte and 0x80 after the 32nd.
// ----------------------------------------------------------------------------
module lcd_init_sequencer #(
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_4MS   = 205000,
    parameter int unsigned T_100US = 5000,
    parameter int unsigned T_40US  = 2000,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic                       Clock,
    input  logic                       Reset,
    lcd_init_sequencer_if.slave        req,
    output logic                       oInit_Done,
    output logic                       oLCD_RS,
    output logic                       oLCD_RW,
    output logic                       oWr_Go,
    output logic [1:0]                 oWr_Mode,
    output logic [3:0]                 oWr_Nibble,
    output logic [7:0]                 oWr_Byte,
    input  logic                       iWr_Done
);

    // A wait of N cycles ends on the cycle the counter reads N-1.
    localparam logic [19:0] PWR_LAST  = 20'(T_PWR   - 1);
    localparam logic [19:0] T4_LAST   = 20'(T_4MS   - 1);
    localparam logic [19:0] T100_LAST = 20'(T_100US - 1);
    localparam logic [19:0] T40_LAST  = 20'(T_40US  - 1);
    localparam logic [19:0] CLR_LAST  = 20'(T_CLR   - 1);

    typedef enum logic [3:0] {
        S_PWR_WAIT,
        S_INIT_NIB,
        S_INIT_WAIT,
        S_CFG_BYTE,
        S_CFG_GAP,
        S_CLR_WAIT,
        S_IDLE,
        S_XFER,
        S_XFER_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q,   cnt_d;
    logic [1:0]  idx_q,   idx_d;      // init nibble index, then config byte index
    logic        rs_q,    rs_d;
    logic [7:0]  data_q,  data_d;
    logic        init_done_q, init_done_d;
`ifdef LCD_LINE_WRAP_EN
    logic [4:0]  col_q,   col_d;
    logic        auto_q,  auto_d;     // current transfer is an inserted line command
`endif

    logic [19:0] init_last;
    logic [7:0]  cfg_byte;

    function automatic logic [7:0] swap_nib(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

    always_comb begin
        case (idx_q)
            2'd0:    init_last = T4_LAST;
            2'd1:    init_last = T100_LAST;
            default: init_last = T40_LAST;
        endcase
    end

    always_comb begin
        case (idx_q)
            2'd0:    cfg_byte = 8'h28;   // 4-bit, 2 lines, 5x8
            2'd1:    cfg_byte = 8'h06;   // entry mode: increment, no shift
            2'd2:    cfg_byte = 8'h0C;   // display on, cursor off
            default: cfg_byte = 8'h01;   // clear display
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        cnt_d            = '0;
        idx_d            = idx_q;
        rs_d             = rs_q;
        data_d           = data_q;
        init_done_d      = init_done_q;
        req.oReq_Ready   = 1'b0;
        oWr_Go           = 1'b0;
        oWr_Mode         = 2'd0;
        oWr_Nibble       = 4'd0;
        oWr_Byte         = 8'd0;
`ifdef LCD_LINE_WRAP_EN
        col_d            = col_q;
        auto_d           = auto_q;
`endif

        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    idx_d   = 2'd0;
                    state_d = S_INIT_NIB;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_INIT_NIB: begin
                oWr_Go     = 1'b1;
                oWr_Nibble = (idx_q == 2'd3) ? 4'h2 : 4'h3;
                if (iWr_Done) state_d = S_INIT_WAIT;
            end

            S_INIT_WAIT: begin
                if (cnt_q == init_last) begin
                    // The 2-bit index wraps 3 -> 0, ready for the config bytes.
                    idx_d   = idx_q + 2'd1;
                    state_d = (idx_q == 2'd3) ? S_CFG_BYTE : S_INIT_NIB;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_CFG_BYTE: begin
                oWr_Go   = 1'b1;
                oWr_Mode = 2'd1;
                oWr_Byte = swap_nib(cfg_byte);
                if (iWr_Done) state_d = S_CFG_GAP;
            end

            S_CFG_GAP: begin
                // One cycle with Go low returns the writer to its reset state.
                if (idx_q == 2'd3) begin
                    idx_d   = 2'd0;
                    state_d = S_CLR_WAIT;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_CFG_BYTE;
                end
            end

            S_CLR_WAIT: begin
                if (cnt_q == CLR_LAST) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            S_IDLE: begin
                req.oReq_Ready = 1'b1;
                if (req.iReq_Valid) begin
                    // RS is updated while Go is still low, so it is set up
                    // before the writer raises its first enable.
                    rs_d    = req.iReq_RS;
                    data_d  = req.iReq_Data;
`ifdef LCD_LINE_WRAP_EN
                    auto_d  = 1'b0;
`endif
                    state_d = S_XFER;
                end
            end

            S_XFER: begin
                oWr_Go   = 1'b1;
                oWr_Mode = 2'd1;
                oWr_Byte = swap_nib(data_q);
                if (iWr_Done) state_d = S_XFER_GAP;
            end

            S_XFER_GAP: begin
                state_d = S_IDLE;
                // Clear (0x01) and home (0x02/0x03) need the long extra wait.
                if (!rs_q && data_q[7:2] == 6'd0 && data_q[1:0] != 2'd0)
                    state_d = S_CLR_WAIT;
`ifdef LCD_LINE_WRAP_EN
                if (rs_q) begin
                    // 31 + 1 wraps the 5-bit column back to 0 on line 1.
                    col_d = col_q + 5'd1;
                    if (col_q == 5'd15 || col_q == 5'd31) begin
                        rs_d    = 1'b0;
                        data_d  = (col_q == 5'd15) ? 8'hC0 : 8'h80;
                        auto_d  = 1'b1;
                        state_d = S_XFER;
                    end
                end else if (!auto_q) begin
                    // A host command may move the cursor; restart column tracking.
                    col_d = 5'd0;
                end
`endif
            end

            default: state_d = S_PWR_WAIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from the same pre-edge snapshot.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= S_PWR_WAIT;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            rs_q        <= 1'b0;
            data_q      <= 8'd0;
            init_done_q <= 1'b0;
`ifdef LCD_LINE_WRAP_EN
            col_q       <= 5'd0;
            auto_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
`ifdef LCD_LINE_WRAP_EN
            col_q       <= col_d;
            auto_q      <= auto_d;
`endif
        end
    end

    assign oInit_Done = init_done_q;
    assign oLCD_RS    = rs_q;
    assign oLCD_RW    = 1'b0;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// ----------------------------------------------------------------------------
// tb_lcd_init_sequencer
//   Self-checking bench for lcd_init_sequencer with shortened timing. A writer
//   model answers each Go with a one-cycle Done three cycles later; every
//   writer transfer is compared against a queue of expected transfers.
// ----------------------------------------------------------------------------
module tb_lcd_init_sequencer;

    localparam int unsigned TB_PWR   = 20;
    localparam int unsigned TB_4MS   = 12;
    localparam int unsigned TB_100US = 8;
    localparam int unsigned TB_40US  = 5;
    localparam int unsigned TB_CLR   = 10;
    localparam int          LIMIT    = 3000;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] nib;
        logic [7:0] byt;
        logic       rs;
    } xact_t;

    logic       Clock;
    logic       Reset;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       wr_go;
    logic [1:0] wr_mode;
    logic [3:0] wr_nib;
    logic [7:0] wr_byte;
    logic       wr_done;

    int    n_tests;
    int    n_fail;
    int    go_cyc;
    xact_t exp_q[$];

    lcd_init_sequencer_if req_if ();

    lcd_init_sequencer #(
        .T_PWR   (TB_PWR),
        .T_4MS   (TB_4MS),
        .T_100US (TB_100US),
        .T_40US  (TB_40US),
        .T_CLR   (TB_CLR)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .req        (req_if),
        .oInit_Done (init_done),
        .oLCD_RS    (lcd_rs),
        .oLCD_RW    (lcd_rw),
        .oWr_Go     (wr_go),
        .oWr_Mode   (wr_mode),
        .oWr_Nibble (wr_nib),
        .oWr_Byte   (wr_byte),
        .iWr_Done   (wr_done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Writer model and scoreboard: capture each transfer on its first Go cycle.
    always @(negedge Clock) begin
        if (!wr_go) begin
            go_cyc  = 0;
            wr_done = 1'b0;
        end else begin
            go_cyc++;
            wr_done = (go_cyc == 3);
            if (go_cyc == 1) begin
                xact_t obs;
                xact_t exp;
                obs = '{mode: wr_mode, nib: wr_nib, byt: wr_byte, rs: lcd_rs};
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard: unexpected transfer mode=%0d nib=%h byte=%h rs=%b",
                             obs.mode, obs.nib, obs.byt, obs.rs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL scoreboard: got mode=%0d nib=%h byte=%h rs=%b, want mode=%0d nib=%h byte=%h rs=%b",
                                 obs.mode, obs.nib, obs.byt, obs.rs, exp.mode, exp.nib, exp.byt, exp.rs);
                    end
                end
            end
        end
    end

    task automatic push_nib(input logic [3:0] n);
        exp_q.push_back('{mode: 2'd0, nib: n, byt: 8'h00, rs: 1'b0});
    endtask

    task automatic push_byte(input logic [7:0] b, input logic rs);
        exp_q.push_back('{mode: 2'd1, nib: 4'h0, byt: {b[3:0], b[7:4]}, rs: rs});
    endtask

    task automatic push_init_seq();
        push_nib(4'h3); push_nib(4'h3); push_nib(4'h3); push_nib(4'h2);
        push_byte(8'h28, 1'b0); push_byte(8'h06, 1'b0);
        push_byte(8'h0C, 1'b0); push_byte(8'h01, 1'b0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_if.oReq_Ready && n < LIMIT) begin @(negedge Clock); n++; end
    endtask

    task automatic wait_init_done(output int n);
        n = 0;
        while (!init_done && n < LIMIT) begin @(negedge Clock); n++; end
    endtask

    // Count clock edges from the fall of Go until Ready is high again.
    task automatic go_fall_to_ready(output int n);
        int k;
        k = 0;
        while (wr_go && k < LIMIT) begin @(negedge Clock); k++; end
        n = 0;
        while (!req_if.oReq_Ready && n < LIMIT) begin @(negedge Clock); n++; end
    endtask

    // Called at a negedge with Ready high: one-cycle request.
    task automatic send(input logic rs, input logic [7:0] d);
        push_byte(d, rs);
        req_if.iReq_Valid = 1'b1;
        req_if.iReq_RS    = rs;
        req_if.iReq_Data  = d;
        @(negedge Clock);
        req_if.iReq_Valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] got;
        Reset = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        got = {wr_go, req_if.oReq_Ready, init_done, lcd_rs, lcd_rw, wr_mode, wr_nib, wr_byte};
        n_tests++;
        if (got !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
    endtask

    task automatic test_init();
        int n;
        push_init_seq();
        Reset = 1'b1;
        n = 0;
        while (!wr_go && n < LIMIT) begin @(negedge Clock); n++; end
        n_tests++;
        if (n != TB_PWR) begin n_fail++; $display("FAIL pwr_wait: got %0d cycles want %0d", n, TB_PWR); end
        while (wr_go) @(negedge Clock);
        n = 0;
        while (!wr_go && n < LIMIT) begin @(negedge Clock); n++; end
        n_tests++;
        if (n != TB_4MS) begin n_fail++; $display("FAIL wait_4ms: got %0d cycles want %0d", n, TB_4MS); end
        while (wr_go) @(negedge Clock);
        n = 0;
        while (!wr_go && n < LIMIT) begin @(negedge Clock); n++; end
        n_tests++;
        if (n != TB_100US) begin n_fail++; $display("FAIL wait_100us: got %0d cycles want %0d", n, TB_100US); end
        n_tests++;
        if (req_if.oReq_Ready !== 1'b0) begin n_fail++; $display("FAIL ready_during_init: got %b want 0", req_if.oReq_Ready); end
        wait_init_done(n);
        n_tests++;
        if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b want 1", init_done); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL init_sequence: %0d transfers missing, want 0", exp_q.size()); end
    endtask

    task automatic test_handshake();
        int n;
        wait_ready(n);
        send(1'b1, 8'h41);
        n_tests++;
        if ({req_if.oReq_Ready, lcd_rs, wr_go, wr_mode, wr_byte} !== {1'b0, 1'b1, 1'b1, 2'd1, 8'h14}) begin
            n_fail++;
            $display("FAIL accept_data: got ready=%b rs=%b go=%b mode=%0d byte=%h want 0 1 1 1 14",
                     req_if.oReq_Ready, lcd_rs, wr_go, wr_mode, wr_byte);
        end
        go_fall_to_ready(n);
        n_tests++;
        if (n != 1) begin n_fail++; $display("FAIL data_ready_return: got %0d cycles want 1", n); end
    endtask

    task automatic test_clear();
        int n;
        wait_ready(n);
        send(1'b0, 8'h01);
        go_fall_to_ready(n);
        n_tests++;
        if (n != TB_CLR + 1) begin n_fail++; $display("FAIL clear_wait: got %0d cycles want %0d", n, TB_CLR + 1); end
        send(1'b0, 8'h0C);
        go_fall_to_ready(n);
        n_tests++;
        if (n != 1) begin n_fail++; $display("FAIL plain_cmd_wait: got %0d cycles want 1", n); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL clear_transfers: %0d transfers missing, want 0", exp_q.size()); end
    endtask

    task automatic test_held_valid();
        int n;
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        push_init_seq();
        push_byte(8'h5A, 1'b1);
        req_if.iReq_Valid = 1'b1;
        req_if.iReq_RS    = 1'b1;
        req_if.iReq_Data  = 8'h5A;
        Reset = 1'b1;
        @(negedge Clock);
        wait_ready(n);
        n_tests++;
        if (init_done !== 1'b1 || n >= LIMIT) begin
            n_fail++;
            $display("FAIL held_off: ready before init_done (init_done=%b, %0d cycles)", init_done, n);
        end
        @(negedge Clock);
        req_if.iReq_Valid = 1'b0;
        repeat (20) @(negedge Clock);
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL held_accept_once: %0d transfers missing, want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int n;
        wait_ready(n);
        send(1'b1, 8'h7E);
        Reset = 1'b0;
        @(negedge Clock);
        n_tests++;
        if ({wr_go, req_if.oReq_Ready, lcd_rs, init_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_abort: got go=%b ready=%b rs=%b done=%b want 0 0 0 0",
                     wr_go, req_if.oReq_Ready, lcd_rs, init_done);
        end
        push_init_seq();
        Reset = 1'b1;
        wait_init_done(n);
        n_tests++;
        if (init_done !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reinit: got init_done=%b, %0d transfers missing, want 1 and 0", init_done, exp_q.size());
        end
    endtask

`ifdef LCD_LINE_WRAP_EN
    task automatic test_line_wrap();
        int n;
        for (int i = 0; i < 32; i++) begin
            wait_ready(n);
            send(1'b1, 8'h41 + 8'(i));
            if (i == 15) push_byte(8'hC0, 1'b0);
            if (i == 31) push_byte(8'h80, 1'b0);
        end
        wait_ready(n);
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL line_wrap: %0d transfers missing, want 0", exp_q.size()); end
    endtask
`endif

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        go_cyc            = 0;
        wr_done           = 1'b0;
        Reset             = 1'b0;
        req_if.iReq_Valid = 1'b0;
        req_if.iReq_RS    = 1'b0;
        req_if.iReq_Data  = 8'h00;
        test_reset();
        test_init();
        test_handshake();
        test_clear();
        test_held_valid();
        test_reset_mid();
`ifdef LCD_LINE_WRAP_EN
        test_line_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
